// File: rtl/force_overlay_pkg.sv
// force_overlay_pkg: shared types for the force/release overlay bank.
// Holds the command opcodes, FSM states and the channel-index width helper.
package force_overlay_pkg;

  typedef enum logic [1:0] {
    OP_READ        = 2'd0,
    OP_FORCE       = 2'd1,
    OP_RELEASE     = 2'd2,
    OP_RELEASE_ALL = 2'd3
  } ovl_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_RESP  = 2'd2
  } ovl_state_e;

  // Channel index width, at least one bit.
  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/force_overlay_bank_if.sv
// force_overlay_bank_if: command/response port of the overlay bank.
// master = debug bridge side, slave = overlay bank side.
interface force_overlay_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 64
);
  import force_overlay_pkg::*;

  localparam int CH_W = ch_w(NUM_CH);

  logic              cmd_valid;
  logic              cmd_ready;
  ovl_op_e           cmd_op;
  logic [CH_W-1:0]   cmd_ch;
  logic [WIDTH-1:0]  cmd_mask;
  logic [WIDTH-1:0]  cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic [WIDTH-1:0]  rsp_forced;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_ch,
    output cmd_mask, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid,
    input  rsp_data, rsp_forced, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch,
    input  cmd_mask, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid,
    output rsp_data, rsp_forced, rsp_err
  );

endinterface

// File: rtl/force_overlay_chan.sv
// force_overlay_chan: one overlay channel (driven copy, force mask/value).
// Ports: drv_* driver update; frc/rel apply strobes with mask/data;
// eff/frc_mask current state; nxt_eff/nxt_mask state after this edge.
module force_overlay_chan #(
  parameter int WIDTH           = 64,
  parameter int HOLD_ON_RELEASE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drv_valid,
  input  logic [WIDTH-1:0] drv_data,
  input  logic             frc,
  input  logic             rel,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] eff,
  output logic [WIDTH-1:0] frc_mask,
  output logic [WIDTH-1:0] nxt_eff,
  output logic [WIDTH-1:0] nxt_mask
);

  logic [WIDTH-1:0] drv_q;
  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] nxt_drv;
  logic [WIDTH-1:0] nxt_val;
  logic [WIDTH-1:0] rel_bits;

  // Only bits actually forced carry a value worth holding.
  assign rel_bits = mask & frc_mask;

  always_comb begin
    nxt_drv  = drv_q;
    nxt_mask = frc_mask;
    nxt_val  = val_q;
    if (frc) begin
      nxt_mask = frc_mask | mask;
      nxt_val  = (val_q & ~mask) | (data & mask);
    end
    if (rel) begin
      nxt_mask = frc_mask & ~mask;
      if (HOLD_ON_RELEASE != 0)
        nxt_drv = (drv_q & ~rel_bits) | (val_q & rel_bits);
    end
    // A driver write in the same cycle beats the held copy.
    if (drv_valid)
      nxt_drv = drv_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drv_q    <= '0;
      frc_mask <= '0;
      val_q    <= '0;
    end else begin
      drv_q    <= nxt_drv;
      frc_mask <= nxt_mask;
      val_q    <= nxt_val;
    end
  end

  assign eff     = (drv_q & ~frc_mask) | (val_q & frc_mask);
  assign nxt_eff = (nxt_drv & ~nxt_mask) | (nxt_val & nxt_mask);

endmodule

// File: rtl/force_overlay_bank.sv
// force_overlay_bank: multi-channel force/release overlay with cmd FSM.
// Ports: clk, rst (async, high); drv_valid/drv_data per-channel driver;
// bus (cmd/rsp handshake); eff_data merged values; forced_any per channel.
module force_overlay_bank
  import force_overlay_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int WIDTH           = 64,
  parameter int HOLD_ON_RELEASE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       drv_valid,
  input  logic [NUM_CH*WIDTH-1:0] drv_data,
  force_overlay_bank_if.slave     bus,
  output logic [NUM_CH*WIDTH-1:0] eff_data,
  output logic [NUM_CH-1:0]       forced_any
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(NUM_CH);

  ovl_state_e       state;
  ovl_op_e          op_q;
  logic [CH_W-1:0]  ch_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] data_q;
  logic             err;
  logic             apply;
  logic [WIDTH-1:0] op_mask;
  logic [WIDTH-1:0] sel_eff;
  logic [WIDTH-1:0] sel_msk;
  logic [WIDTH-1:0] nxt_eff [NUM_CH];
  logic [WIDTH-1:0] nxt_msk [NUM_CH];
  logic [WIDTH-1:0] frc_msk [NUM_CH];

  assign err   = {1'b0, ch_q} >= CH_LIM;
  assign apply = (state == S_APPLY) && !err;

  assign op_mask = (op_q == OP_RELEASE_ALL) ?
                   {WIDTH{1'b1}} : mask_q;

  assign bus.cmd_ready = (state == S_IDLE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    logic frc;
    logic rel;

    assign hit = (ch_q == CH_W'(i));
    assign frc = apply && hit && (op_q == OP_FORCE);
    assign rel = apply &&
                 ((hit && (op_q == OP_RELEASE)) ||
                  (op_q == OP_RELEASE_ALL));

    force_overlay_chan #(
      .WIDTH           (WIDTH),
      .HOLD_ON_RELEASE (HOLD_ON_RELEASE)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .drv_valid (drv_valid[i]),
      .drv_data  (drv_data[i*WIDTH +: WIDTH]),
      .frc       (frc),
      .rel       (rel),
      .mask      (op_mask),
      .data      (data_q),
      .eff       (eff_data[i*WIDTH +: WIDTH]),
      .frc_mask  (frc_msk[i]),
      .nxt_eff   (nxt_eff[i]),
      .nxt_mask  (nxt_msk[i])
    );

    assign forced_any[i] = |frc_msk[i];
  end

  // Out-of-range channels match nothing and read back as zero.
  always_comb begin
    sel_eff = '0;
    sel_msk = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        sel_eff = nxt_eff[i];
        sel_msk = nxt_msk[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      op_q           <= OP_READ;
      ch_q           <= '0;
      mask_q         <= '0;
      data_q         <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_forced <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q   <= bus.cmd_op;
            ch_q   <= bus.cmd_ch;
            mask_q <= bus.cmd_mask;
            data_q <= bus.cmd_data;
            state  <= S_APPLY;
          end
        end
        S_APPLY: begin
          bus.rsp_valid  <= 1'b1;
          bus.rsp_data   <= sel_eff;
          bus.rsp_forced <= sel_msk;
          bus.rsp_err    <= err;
          state          <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
